// File: rtl/vending_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : vending_controller_if
//  Description : Coin-slot, dispense and change handshake bundle for the
//                vending transaction controller.
//  Revision    : 1.0
// ============================================================================
interface vending_controller_if #(
    parameter int CREDIT_W = 4
) ();
    logic                io_coin0_valid;
    logic [1:0]          io_coin0_value;
    logic                io_coin0_ready;
    logic                io_coin1_valid;
    logic [1:0]          io_coin1_value;
    logic                io_coin1_ready;
    logic                io_dispense_valid;
    logic                io_dispense_ready;
    logic                io_change_valid;
    logic                io_change_ready;
    logic [CREDIT_W-1:0] io_change_value;
    logic [CREDIT_W-1:0] io_credit;
    logic                io_busy;

    // Environment side: coin slots plus the downstream dispenser/change unit.
    modport master (
        output io_coin0_valid, io_coin0_value, io_coin1_valid, io_coin1_value,
        output io_dispense_ready, io_change_ready,
        input  io_coin0_ready, io_coin1_ready, io_dispense_valid,
        input  io_change_valid, io_change_value, io_credit, io_busy
    );

    modport slave (
        input  io_coin0_valid, io_coin0_value, io_coin1_valid, io_coin1_value,
        input  io_dispense_ready, io_change_ready,
        output io_coin0_ready, io_coin1_ready, io_dispense_valid,
        output io_change_valid, io_change_value, io_credit, io_busy
    );
endinterface
`default_nettype wire

// File: rtl/vending_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vending_controller
//  Description : Sequences a sale: round-robin coin collection from two slots,
//                dispense handshake at PRICE, then change return handshake.
//  Revision    : 1.0
// ============================================================================
module vending_controller #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    vending_controller_if.slave   bus
);

    localparam logic [1:0] c_ST_COLLECT  = 2'd0;
    localparam logic [1:0] c_ST_DISPENSE = 2'd1;
    localparam logic [1:0] c_ST_CHANGE   = 2'd2;

    localparam logic [CREDIT_W-1:0] c_PRICE = CREDIT_W'(PRICE);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                prio_q, prio_d;

    logic                w_collect;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic [1:0]          w_coin_value;
    logic [CREDIT_W-1:0] w_sum;
    logic [CREDIT_W-1:0] w_remainder;

    assign w_collect = (state_q == c_ST_COLLECT);

    // prio_q = 1 means slot 1 wins a simultaneous request.
    assign w_grant0 = bus.io_coin0_valid & (~bus.io_coin1_valid | ~prio_q);
    assign w_grant1 = bus.io_coin1_valid & (~bus.io_coin0_valid |  prio_q);

    assign bus.io_coin0_ready = w_collect & w_grant0 & ~reset;
    assign bus.io_coin1_ready = w_collect & w_grant1 & ~reset;
    assign w_accept           = bus.io_coin0_ready | bus.io_coin1_ready;

    assign w_coin_value = w_grant0 ? bus.io_coin0_value : bus.io_coin1_value;
    assign w_sum        = credit_q + {{(CREDIT_W-2){1'b0}}, w_coin_value};
    assign w_remainder  = credit_q - c_PRICE;

    // Outputs are forced quiet during reset so no handshake can complete then.
    assign bus.io_dispense_valid = (state_q == c_ST_DISPENSE) & ~reset;
    assign bus.io_change_valid   = (state_q == c_ST_CHANGE) & ~reset;
    assign bus.io_change_value   = bus.io_change_valid ? credit_q : '0;
    assign bus.io_credit         = reset ? '0 : credit_q;
    assign bus.io_busy           = ~w_collect & ~reset;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        prio_d   = prio_q;
        case (state_q)
            c_ST_COLLECT: begin
                if (w_accept) begin
                    credit_d = w_sum;
                    prio_d   = w_grant0;
                    if (w_sum >= c_PRICE) begin
                        state_d = c_ST_DISPENSE;
                    end
                end
            end
            c_ST_DISPENSE: begin
                if (bus.io_dispense_ready) begin
                    credit_d = w_remainder;
                    state_d  = (w_remainder != '0) ? c_ST_CHANGE : c_ST_COLLECT;
                end
            end
            c_ST_CHANGE: begin
                if (bus.io_change_ready) begin
                    credit_d = '0;
                    state_d  = c_ST_COLLECT;
                end
            end
            default: begin
                credit_d = '0;
                state_d  = c_ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_ST_COLLECT;
            credit_q <= '0;
            prio_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            prio_q   <= prio_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/vending_controller.md
# vending_controller

Transaction controller that sits in front of the coin-accumulating vending FSM and sequences a complete sale. It arbitrates two independent coin slots onto one credit accumulator, then drives a dispense handshake once credit reaches the item price, then a change-return handshake for any overpayment. The accept → dispense → change sequence uses valid/ready handshakes throughout, so the slow mechanical stages downstream can stall it.

## Interface
Parameters:
- PRICE, 4, item price in credit units; legal range 1..(2^CREDIT_W − 3).
- CREDIT_W, 4, width of the credit accumulator and the change value.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_coin0_valid  in  1  slot 0 offers a coin.
- io_coin0_value  in  2  slot 0 coin value in credit units (0..3).
- io_coin0_ready  out  1  slot 0 coin accepted this cycle.
- io_coin1_valid  in  1  slot 1 offers a coin.
- io_coin1_value  in  2  slot 1 coin value in credit units (0..3).
- io_coin1_ready  out  1  slot 1 coin accepted this cycle.
- io_dispense_valid  out  1  request to dispense one item.
- io_dispense_ready  in  1  dispenser takes the request.
- io_change_valid  out  1  change return request.
- io_change_value  out  CREDIT_W  change amount; valid only while io_change_valid is high.
- io_credit  out  CREDIT_W  registered current credit.
- io_busy  out  1  high in any state other than COLLECT.

## Operation
- A handshake completes on any cycle where valid and ready are both high at the rising edge.
- State machine states: COLLECT, DISPENSE, CHANGE. Reset state is COLLECT.
- **COLLECT:**
  - If exactly one slot has valid high, that slot is granted.
  - If both slots have valid high, the slot holding the round-robin priority is granted.
  - io_coinN_ready = (state == COLLECT) & grantN & !reset. Readies are combinational from the valids, and at most one is high per cycle.
  - On an accept: credit ← credit + value, and priority moves to the other slot. A value of 0 is accepted, leaves credit unchanged, and still moves priority.
  - If the new credit ≥ PRICE, next state is DISPENSE; otherwise stay in COLLECT.
- **DISPENSE:**
  - io_dispense_valid = 1, held until the handshake.
  - On the handshake: credit ← credit − PRICE.
  - Next state is CHANGE if the remainder is nonzero, else COLLECT.
- **CHANGE:**
  - io_change_valid = 1 and io_change_value = credit, both held stable until the handshake.
  - On the handshake: credit ← 0 and next state is COLLECT.
- Width rule: the maximum credit is PRICE−1+3, which fits in CREDIT_W under the legal PRICE range. The accumulator never wraps, and no saturation logic is required.
- Round-robin priority resets to slot 0.
- Upstream must hold valid and value stable until ready; the controller does not check this.

## Timing
- Reset values: state COLLECT, credit 0, priority slot 0.
- Output values under reset:
  - io_credit 0, io_busy 0, io_dispense_valid 0, io_change_valid 0, io_change_value 0.
  - Both readies are 0 while reset is high.
- Coin accepted at edge T → io_credit updated at T+1.
  - If the price is reached, io_dispense_valid and io_busy are high from T+1.
  - Fastest sale: price-reaching coin at T, dispense handshake at T+1.
- Dispense handshake at edge T:
  - With a remainder, io_change_valid is high from T+1.
  - Without a remainder, COLLECT is entered at T+1 and readies may assert in that cycle.
- Change handshake at edge T → COLLECT at T+1, io_credit = 0 at T+1.
- io_dispense_ready held high → io_dispense_valid lasts exactly one cycle; same rule for change.
- No coin is accepted in DISPENSE or CHANGE: readies are 0 there, even if valids are high.
- Reset asserted mid-DISPENSE or mid-CHANGE:
  - State returns to COLLECT and credit goes to 0 on the next edge.
  - Pending credit is discarded and no change is output. This is intended.
- Both valids held continuously in COLLECT → grants alternate 0,1,0,1… starting from the current priority.

## Test plan
- Exact payment, slot 0 only, PRICE=4: values 2, 2 accepted on consecutive cycles → io_credit 2 then 4; one dispense handshake; io_change_valid never asserted; io_credit 0 afterwards.
- Overpay: values 1, 2, 2 → credit 1, 3, 5; dispense handshake; io_change_value = 1; after the change handshake io_credit 0 and io_busy 0.
- Contention, both slots valid with value 1 every cycle from reset:
  - Accepts alternate slot0, slot1, slot0, slot1.
  - Dispense fires after the 4th accept.
  - Both readies stay 0 until the sale completes.
- Back-pressure: io_dispense_ready held low for 5 cycles → io_dispense_valid stays high, no coin accepted and credit held at 4; change handshake stalled the same way with io_change_value stable.
- Reset mid-CHANGE, credit 2: one reset cycle → io_change_valid 0, io_credit 0, state COLLECT, priority slot 0, and the next coin is accepted normally.
- Zero-value coins: value 0 on slot 1 accepted → credit unchanged and priority toggles; a subsequent simultaneous request is granted to slot 0.
